// File: rtl/ebus_diag_pkg.sv
// Shared types and widths for the EBUS diagnostic sequencer.
package ebus_diag_pkg;

  localparam int EBUS_W = 36;
  localparam int DS_W   = 7;

  typedef enum logic [1:0] {
    FUNC    = 2'd0,
    READ    = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } tDiagReqType;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    SAMPLE,
    ACK
  } tSeqState;

  function automatic logic [1:0] one_hot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ebus_diag_pick.sv
// Two-way grant picker. Fixed priority (requester 0) by default;
// round-robin on ties when EBUS_DIAG_RR_EN is defined.
module ebus_diag_pick (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic       grant
);

`ifdef EBUS_DIAG_RR_EN
  // ptr is the requester granted last; on a tie the other one wins
  assign grant = (eligible == 2'b11) ? ~ptr : ~eligible[0];
`else
  logic unused_ptr;
  assign unused_ptr = ptr;
  assign grant      = ~eligible[0];
`endif

endmodule

// File: rtl/ebus_diag_sequencer.sv
// Arbitrates two requesters onto the EBUS diagnostic path and sequences
// FUNC/READ/WRITE/RELEASE with fixed strobe and sample timing. Macro: EBUS_DIAG_RR_EN.
module ebus_diag_sequencer
  import ebus_diag_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int SAMPLE_DELAY  = 1,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              CROBAR,
  input  logic [1:0]        req,
  input  logic [1:0]        reqType0,
  input  logic [1:0]        reqType1,
  input  logic [DS_W-1:0]   reqDs0,
  input  logic [DS_W-1:0]   reqDs1,
  input  logic [EBUS_W-1:0] reqData0,
  input  logic [EBUS_W-1:0] reqData1,
  output logic [1:0]        ack,
  output logic [EBUS_W-1:0] rdata,
  output logic [DS_W-1:0]   ebusDs,
  output logic              ebusDiagStrobe,
  output logic              ebusDriving,
  output logic [EBUS_W-1:0] ebusDataOut,
  input  logic [EBUS_W-1:0] ebusDataIn,
  output logic              locked,
  output logic              owner
);

  localparam int S_EFF = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
  localparam int D_EFF = (SAMPLE_DELAY < 1) ? 1 : SAMPLE_DELAY;
  localparam logic [CNT_W-1:0] S_LOAD = CNT_W'(S_EFF - 1);
  localparam logic [CNT_W-1:0] D_LOAD = CNT_W'(D_EFF - 1);

  tSeqState          state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  tDiagReqType       type_reg, type_next;
  logic              grant_reg, grant_next;
  logic [DS_W-1:0]   ds_reg, ds_next;
  logic              strobe_reg, strobe_next;
  logic              driving_reg, driving_next;
  logic [EBUS_W-1:0] data_out_reg, data_out_next;
  logic              locked_reg, locked_next;
  logic              owner_reg, owner_next;
  logic [EBUS_W-1:0] rdata_reg, rdata_next;
  logic [1:0]        ack_reg, ack_next;

  logic [1:0]        eligible;
  logic              ptr;
  logic              pick;
  tDiagReqType       sel_type;
  logic [EBUS_W-1:0] sel_data;

  // While locked only the lock holder may be served
  assign eligible = req & (locked_reg ? one_hot(owner_reg) : 2'b11);
  assign sel_type = tDiagReqType'(pick ? reqType1 : reqType0);
  assign sel_data = pick ? reqData1 : reqData0;

  ebus_diag_pick u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .grant    (pick)
  );

`ifdef EBUS_DIAG_RR_EN
  logic ptr_reg;
  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      ptr_reg <= 1'b1;
    end else if (state_reg == IDLE && eligible != 2'b00) begin
      ptr_reg <= pick;
    end
  end
  assign ptr = ptr_reg;
`else
  assign ptr = 1'b1;
`endif

  // Bus-facing outputs are loaded on the grant edge so ds is valid during SETUP
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    type_next     = type_reg;
    grant_next    = grant_reg;
    ds_next       = ds_reg;
    strobe_next   = strobe_reg;
    driving_next  = driving_reg;
    data_out_next = data_out_reg;
    locked_next   = locked_reg;
    owner_next    = owner_reg;
    rdata_next    = rdata_reg;
    ack_next      = 2'b00;
    case (state_reg)
      IDLE: begin
        if (eligible != 2'b00) begin
          grant_next = pick;
          type_next  = sel_type;
          ds_next    = pick ? reqDs1 : reqDs0;
          state_next = SETUP;
          if (sel_type == WRITE) begin
            driving_next  = 1'b1;
            data_out_next = sel_data;
            locked_next   = 1'b1;
            owner_next    = pick;
          end else if (sel_type == RELEASE) begin
            driving_next  = 1'b0;
            data_out_next = '0;
            locked_next   = 1'b0;
          end
        end
      end
      SETUP: begin
        case (type_reg)
          FUNC, WRITE: begin
            strobe_next = 1'b1;
            cnt_next    = S_LOAD;
            state_next  = STROBE;
          end
          READ: begin
            cnt_next   = D_LOAD;
            state_next = SAMPLE;
          end
          default: begin
            ack_next   = one_hot(grant_reg);
            state_next = ACK;
          end
        endcase
      end
      STROBE: begin
        if (cnt_reg == '0) begin
          strobe_next = 1'b0;
          ack_next    = one_hot(grant_reg);
          state_next  = ACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (cnt_reg == '0) begin
          rdata_next = ebusDataIn;
          ack_next   = one_hot(grant_reg);
          state_next = ACK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      type_reg     <= FUNC;
      grant_reg    <= 1'b0;
      ds_reg       <= '0;
      strobe_reg   <= 1'b0;
      driving_reg  <= 1'b0;
      data_out_reg <= '0;
      locked_reg   <= 1'b0;
      owner_reg    <= 1'b0;
      rdata_reg    <= '0;
      ack_reg      <= 2'b00;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      type_reg     <= type_next;
      grant_reg    <= grant_next;
      ds_reg       <= ds_next;
      strobe_reg   <= strobe_next;
      driving_reg  <= driving_next;
      data_out_reg <= data_out_next;
      locked_reg   <= locked_next;
      owner_reg    <= owner_next;
      rdata_reg    <= rdata_next;
      ack_reg      <= ack_next;
    end
  end

  assign ack            = ack_reg;
  assign rdata          = rdata_reg;
  assign ebusDs         = ds_reg;
  assign ebusDiagStrobe = strobe_reg;
  assign ebusDriving    = driving_reg;
  assign ebusDataOut    = data_out_reg;
  assign locked         = locked_reg;
  assign owner          = owner_reg;

endmodule
